cmp_seq: RTL and testbench



---
 rtl/cmp_seq_if.sv | 25 ++
 rtl/cmp_seq.sv | 113 +++++++++++
 tb/tb_cmp_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cmp_seq_if.sv
// Handshake and operand bundle for the sequential comparator.
// The master side requests a compare and the slave side answers with registered results.
interface cmp_seq_if #(
  parameter int unsigned W = 16
) ();
  logic         start;
  logic         signed_mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done_tick;
  logic         aeqb;
  logic         agtb;
  logic         altb;

  modport master (
    output start, signed_mode, a, b,
    input  ready, done_tick, aeqb, agtb, altb
  );

  modport slave (
    input  start, signed_mode, a, b,
    output ready, done_tick, aeqb, agtb, altb
  );
endinterface

// File: rtl/cmp_seq.sv
// Sequential W-bit magnitude/equality comparator, C bits per cycle, MSB chunk first.
// Stops on the first differing chunk; signed compares use offset-binary operands.
module cmp_seq #(
  parameter int unsigned W = 16,
  parameter int unsigned C = 4
) (
  input  logic     clk,
  input  logic     reset,
  cmp_seq_if.slave bus
);

  localparam int unsigned NumChunks = W / C;
  localparam int unsigned KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam logic [KW-1:0] KTop    = KW'(NumChunks - 1);
  localparam logic [W-1:0] SignMask = W'(1) << (W - 1);

  if ((C < 1) || (C > W) || ((W % C) != 0)) begin : g_bad_params
    $error("cmp_seq: C must divide W and satisfy 1 <= C <= W");
  end

  typedef enum logic [1:0] {
    StIdle,
    StOp,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          aeqb_q, aeqb_d;
  logic          agtb_q, agtb_d;
  logic          altb_q, altb_d;
  logic [C-1:0]  chunk_a, chunk_b;

  always_comb begin
    chunk_a = C'(a_q >> (32'(k_q) * C));
    chunk_b = C'(b_q >> (32'(k_q) * C));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    aeqb_d  = aeqb_q;
    agtb_d  = agtb_q;
    altb_d  = altb_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = bus.signed_mode ? (bus.a ^ SignMask) : bus.a;
          b_d     = bus.signed_mode ? (bus.b ^ SignMask) : bus.b;
          k_d     = KTop;
          state_d = StOp;
        end
      end

      StOp: begin
        if (chunk_a != chunk_b) begin
          aeqb_d  = 1'b0;
          agtb_d  = (chunk_a > chunk_b);
          altb_d  = (chunk_a < chunk_b);
          state_d = StDone;
        end else if (k_q == '0) begin
          aeqb_d  = 1'b1;
          agtb_d  = 1'b0;
          altb_d  = 1'b0;
          state_d = StDone;
        end else begin
          k_d = k_q - 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aeqb_q  <= 1'b0;
      agtb_q  <= 1'b0;
      altb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aeqb_q  <= aeqb_d;
      agtb_q  <= agtb_d;
      altb_q  <= altb_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.done_tick = (state_q == StDone);
  assign bus.aeqb      = aeqb_q;
  assign bus.agtb      = agtb_q;
  assign bus.altb      = altb_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed bench for cmp_seq (W=16, C=4): vector table plus handshake and reset sequences.
module tb_cmp_seq;

  localparam int unsigned W = 16;
  localparam int unsigned C = 4;

  logic clk;
  logic reset;

  cmp_seq_if #(.W(W)) bus_if ();

  cmp_seq #(
    .W(W),
    .C(C)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    int           lat;  // cycle index of done_tick after acceptance
    logic         eq;
    logic         gt;
    logic         lt;
  } vec_t;

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    bus_if.a           = v.a;
    bus_if.b           = v.b;
    bus_if.signed_mode = v.sm;
    bus_if.start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    cyc = 1;
    while (!bus_if.done_tick && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(v.lat));
    check({tag, " aeqb"}, 32'(bus_if.aeqb), 32'(v.eq));
    check({tag, " agtb"}, 32'(bus_if.agtb), 32'(v.gt));
    check({tag, " altb"}, 32'(bus_if.altb), 32'(v.lt));
    @(negedge clk);
    check({tag, " ready after done"}, 32'(bus_if.ready), 32'd1);
    check({tag, " single done_tick"}, 32'(bus_if.done_tick), 32'd0);
  endtask

  vec_t vecs[10];
  int   dticks;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset              = 1'b1;
    bus_if.start       = 1'b0;
    bus_if.signed_mode = 1'b0;
    bus_if.a           = '0;
    bus_if.b           = '0;

    vecs[0] = '{16'h1234, 16'h1234, 1'b0, 5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, 2, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{16'h1235, 16'h1234, 1'b0, 5, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFE, 16'hFFFF, 1'b1, 5, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0012, 16'h0034, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h0000, 1'b1, 2, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h00F0, 16'h00E0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'h0001, 1'b1, 2, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b1, 5, 1'b1, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset ready", 32'(bus_if.ready), 32'd1);
    check("reset done_tick", 32'(bus_if.done_tick), 32'd0);
    check("reset results", {29'd0, bus_if.aeqb, bus_if.agtb, bus_if.altb}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle ready", 32'(bus_if.ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start held through a busy compare with operands changing, then re-start with no gap.
    dticks = 0;
    @(negedge clk);
    bus_if.a           = 16'h0100;
    bus_if.b           = 16'h0100;
    bus_if.signed_mode = 1'b0;
    bus_if.start       = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (bus_if.done_tick) dticks++;
      check($sformatf("busy cyc%0d ready", c), 32'(bus_if.ready), 32'd0);
      bus_if.a = 16'($urandom_range(0, 16'h7FFF));
      bus_if.b = bus_if.a + 16'h1111;
    end
    @(negedge clk);
    if (bus_if.done_tick) dticks++;
    check("hold done_tick", 32'(bus_if.done_tick), 32'd1);
    check("hold aeqb", 32'(bus_if.aeqb), 32'd1);
    bus_if.a = 16'h0005;
    bus_if.b = 16'h0009;
    @(negedge clk);
    if (bus_if.done_tick) dticks++;
    check("b2b ready window", 32'(bus_if.ready), 32'd1);
    @(negedge clk);
    bus_if.start = 1'b0;
    check("b2b no gap", 32'(bus_if.ready), 32'd0);
    check("result held aeqb", 32'(bus_if.aeqb), 32'd1);
    check("result held altb", 32'(bus_if.altb), 32'd0);
    for (int c = 8; c <= 11; c++) begin
      @(negedge clk);
      if (bus_if.done_tick) dticks++;
    end
    check("b2b done_tick cyc11", 32'(bus_if.done_tick), 32'd1);
    check("b2b altb", 32'(bus_if.altb), 32'd1);
    check("b2b aeqb", 32'(bus_if.aeqb), 32'd0);
    @(negedge clk);
    if (bus_if.done_tick) dticks++;
    check("done_tick count", 32'(dticks), 32'd2);

    // Reset in op cycle 2 discards the compare.
    @(negedge clk);
    bus_if.a     = 16'h1234;
    bus_if.b     = 16'h1234;
    bus_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midop reset ready", 32'(bus_if.ready), 32'd1);
    check("midop reset results", {29'd0, bus_if.aeqb, bus_if.agtb, bus_if.altb}, 32'd0);
    check("midop reset done_tick", 32'(bus_if.done_tick), 32'd0);
    dticks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_if.done_tick) dticks++;
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.done_tick) dticks++;
    end
    check("no done_tick after reset", 32'(dticks), 32'd0);
    run_vec('{16'h0001, 16'h0002, 1'b0, 5, 1'b0, 1'b0, 1'b1}, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
